trace_capture_unit: RTL
=======================

Name: trace_capture_unit

Overview:
- Parametrised, synthesizable successor to the top-level pipeline test fixture; sits beside `mips` inside the bench/FPGA wrapper.
- Captures architectural write events into an on-chip FIFO:
  - register-file (GRF) writeback events;
  - data-memory (DM) store events.
- Detects program halt or timeout and drains the captured trace over a valid/ready port.
- Replaces free-running fixed-length simulation with a self-terminating, cycle-counted run.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥4.
- DATA_W, 32, width of PC, address and data fields.
- HALT_REPEAT, 4, consecutive cycles with unchanged fetch PC that declare halt.
- MAX_CYCLES, 5000, run-cycle limit before forced timeout.
- CNT_W, 32, width of the cycle counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- f_pc  in  DATA_W  fetch-stage PC.
- grf_we  in  1  GRF write strobe (W stage).
- grf_pc  in  DATA_W  PC of the writing instruction.
- grf_addr  in  5  destination register.
- grf_wd  in  DATA_W  write data.
- dm_we  in  1  DM store strobe (M stage).
- dm_pc  in  DATA_W  PC of the store.
- dm_addr  in  DATA_W  byte address.
- dm_wd  in  DATA_W  store data.
- out_ready  in  1  consumer ready.
- out_valid  out  1  trace entry available.
- out_kind  out  1  0 = GRF, 1 = DM.
- out_pc  out  DATA_W  entry PC.
- out_addr  out  DATA_W  register number (zero-extended) or memory address.
- out_data  out  DATA_W  entry data.
- overflow  out  1  sticky: at least one event dropped.
- done  out  1  run finished and FIFO empty.
- timeout  out  1  sticky: run ended by MAX_CYCLES.
- cycle_cnt  out  CNT_W  cycles spent in RUN.

Behaviour:
- Reset (synchronous, active-high):
  - FIFO emptied;
  - state = RUN;
  - outputs cleared: out_valid, overflow, done, timeout = 0; cycle_cnt = 0; out_* data = 0;
  - halt counter cleared.
- Reset asserted mid-run or mid-drain aborts immediately and discards all entries.
- FSM states: RUN, DRAIN, DONE.
  - RUN:
    - cycle_cnt increments every cycle;
    - events are accepted;
    - halt counter increments when f_pc equals the previous cycle's f_pc, and clears otherwise.
  - RUN→DRAIN when either:
    - halt counter reaches HALT_REPEAT-1; or
    - cycle_cnt == MAX_CYCLES-1, which also sets timeout.
    - If both occur in the same cycle, timeout is still set.
  - DRAIN:
    - events ignored;
    - cycle_cnt frozen;
    - FIFO drains.
  - DRAIN→DONE when the FIFO is empty and no push is pending.
  - DONE: done = 1; holds until reset.
- Capture:
  - Up to 2 pushes per cycle (GRF and DM simultaneously).
  - Order: GRF entry enqueued before DM entry.
  - Free space = DEPTH − count, plus 1 if a pop occurs in the same cycle.
  - If space is insufficient, GRF takes priority, the unfit event is dropped, and overflow is set.
- Output handshake:
  - Registered output: an entry pushed in cycle N is visible on out_valid no earlier than cycle N+1.
  - A pop occurs when out_valid && out_ready.
  - out_* fields are stable while out_valid && !out_ready.
- Counter wrap: cycle_cnt saturates at all-ones and never wraps.
- Empty FIFO: out_valid = 0; out_* hold their last values.

Optional Feature:
- Macro: TRACE_ZERO_FILTER_EN.
- Defined: GRF writes with grf_addr == 0 are discarded before capture (no entry, no overflow effect).
- Undefined: $0 writes are captured like any other GRF write.

Decomposition:
- Package trace_pkg holds:
  - KIND_GRF / KIND_DM constants;
  - state encodings RUN / DRAIN / DONE;
  - the entry record layout: kind + pc + addr + data = 1 + 3·DATA_W bits.
- Sub-module trace_fifo:
  - dual-push, single-pop circular buffer;
  - parameters DEPTH and entry width;
  - push0/push1/pop, count, registered head output.
  - The top level owns the FSM, halt detection, counters and the drop policy.

Test Plan:
- Single GRF write: grf_we=1, addr 5, wd 0x1234, pc 0x3000; out_ready=1 → next cycle out_valid=1, kind 0, addr 5, data 0x1234, pc 0x3000.
- Simultaneous GRF (addr 2, data 0xA) and DM (addr 0x10, data 0xB) → two entries in order GRF then DM on consecutive handshakes.
- Overflow: out_ready=0; push DEPTH+1 GRF events → count = DEPTH, overflow = 1, last event absent. Then out_ready=1 → exactly DEPTH entries, the first DEPTH in order.
- Halt:
  - f_pc held at 0x3010 for 4 cycles with HALT_REPEAT=4 → state DRAIN, cycle_cnt frozen;
  - done=1 one cycle after the final pop; timeout=0.
- Timeout: MAX_CYCLES=20, f_pc incrementing by 4 each cycle → timeout=1, cycle_cnt=20, done once the FIFO is empty.
- $0 write with addr 0, wd 0xFF:
  - TRACE_ZERO_FILTER_EN defined → no out_valid;
  - undefined → one entry with addr 0.
- Reset during DRAIN with 3 entries queued → next cycle out_valid=0, cycle_cnt=0, state RUN.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared definitions for the trace capture unit.
//   KIND_GRF / KIND_DM  : out_kind encodings (GRF writeback, DM store)
//   state_t             : capture FSM states RUN / DRAIN / DONE
//   entry_width()       : packed entry size for a given DATA_W
// Entry layout, MSB first: {kind, pc, addr, data} = 1 + 3*DATA_W bits.
package trace_pkg;

  localparam logic KIND_GRF = 1'b0;
  localparam logic KIND_DM  = 1'b1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int unsigned entry_width(input int unsigned data_w);
    return 1 + 3 * data_w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Dual-push, single-pop circular buffer with a registered head.
//   clk, reset          : clock, synchronous active-high reset
//   push0/data0         : first push slot (enqueued first)
//   push1/data1         : second push slot (enqueued after push0)
//   pop                 : remove the presented head (caller guarantees head_valid)
//   count               : entries held, including the presented head
//   head_valid/head_data: registered head of the queue; head_data holds when empty
// The caller must never push more entries than DEPTH - count + pop.
module trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 97
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push0,
  input  logic [WIDTH-1:0]       data0,
  input  logic                   push1,
  input  logic [WIDTH-1:0]       data1,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output logic                   head_valid,
  output logic [WIDTH-1:0]       head_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [AW-1:0]    wr_second;
  logic [AW-1:0]    wr_next;
  logic [CW-1:0]    kept;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] head_next;

  always_comb begin
    rd_next    = rd_ptr + AW'(pop);
    wr_second  = wr_ptr + AW'(push0);
    wr_next    = wr_ptr + AW'(push0) + AW'(push1);
    kept       = count - CW'(pop);
    count_next = kept + CW'(push0) + CW'(push1);
    // When nothing older survives the pop, the new head is this cycle's
    // first push, which is not yet in the array: bypass it.
    if (kept != '0) begin
      head_next = mem[rd_next];
    end else if (push0) begin
      head_next = data0;
    end else begin
      head_next = data1;
    end
  end

  always_ff @(posedge clk) begin
    if (push0) begin
      mem[wr_ptr] <= data0;
    end
    if (push1) begin
      mem[wr_second] <= data1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      wr_ptr     <= wr_next;
      rd_ptr     <= rd_next;
      count      <= count_next;
      head_valid <= (count_next != '0);
      if (count_next != '0) begin
        head_data <= head_next;
      end
    end
  end

endmodule

// File: rtl/trace_capture_unit.sv
// Trace capture unit: records GRF writeback and DM store events into a FIFO
// while the program runs, detects halt (fetch PC stuck) or cycle timeout,
// then drains the trace over a valid/ready port and reports done.
//   clk, reset               : clock, synchronous active-high reset
//   f_pc                     : fetch PC, used for halt detection
//   grf_we/grf_pc/grf_addr/grf_wd : GRF writeback event
//   dm_we/dm_pc/dm_addr/dm_wd     : DM store event
//   out_ready/out_valid/out_kind/out_pc/out_addr/out_data : trace output
//   overflow (sticky drop), done, timeout (sticky), cycle_cnt (RUN cycles)
// Build option TRACE_ZERO_FILTER_EN: when defined, GRF writes to $0 are
// discarded before capture.
module trace_capture_unit
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned HALT_REPEAT = 4,
  parameter int unsigned MAX_CYCLES  = 5000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] f_pc,
  input  logic              grf_we,
  input  logic [DATA_W-1:0] grf_pc,
  input  logic [4:0]        grf_addr,
  input  logic [DATA_W-1:0] grf_wd,
  input  logic              dm_we,
  input  logic [DATA_W-1:0] dm_pc,
  input  logic [DATA_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wd,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              out_kind,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              overflow,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int unsigned EW = entry_width(DATA_W);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned HW = $clog2(HALT_REPEAT) + 1;

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     fifo_count;
  logic              head_valid;
  logic [EW-1:0]     head_data;
  logic              pop;
  logic              grf_keep;
  logic              grf_ev;
  logic              dm_ev;
  logic [CW-1:0]     space;
  logic              push0;
  logic              push1;
  logic              drop;
  logic [EW-1:0]     grf_entry;
  logic [EW-1:0]     dm_entry;
  logic [DATA_W-1:0] prev_pc;
  logic              prev_valid;
  logic [HW-1:0]     halt_cnt;
  logic [HW-1:0]     halt_cnt_next;
  logic              halt_hit;
  logic              timeout_hit;
  logic              drain_empty;

`ifdef TRACE_ZERO_FILTER_EN
  assign grf_keep = (grf_addr != '0);
`else
  assign grf_keep = 1'b1;
`endif

  assign pop = head_valid && out_ready;

  always_comb begin
    grf_ev    = (state == RUN) && grf_we && grf_keep;
    dm_ev     = (state == RUN) && dm_we;
    grf_entry = {KIND_GRF, grf_pc, DATA_W'(grf_addr), grf_wd};
    dm_entry  = {KIND_DM, dm_pc, dm_addr, dm_wd};
    // A same-cycle pop frees one slot for this cycle's pushes.
    space     = CW'(DEPTH) - fifo_count + CW'(pop);
    push0     = grf_ev && (space != '0);
    push1     = dm_ev && (space > CW'(push0));
    drop      = (grf_ev && !push0) || (dm_ev && !push1);
  end

  always_comb begin
    halt_cnt_next = (prev_valid && (f_pc == prev_pc)) ? halt_cnt + HW'(1) : '0;
    halt_hit      = (halt_cnt_next == HW'(HALT_REPEAT - 1));
    timeout_hit   = (cycle_cnt == CNT_W'(MAX_CYCLES - 1));
    // No pushes happen outside RUN, so empty-after-pop means fully drained.
    drain_empty   = (fifo_count == CW'(pop));
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push0      (push0),
    .data0      (grf_entry),
    .push1      (push1),
    .data1      (push0 ? dm_entry : dm_entry),
    .pop        (pop),
    .count      (fifo_count),
    .head_valid (head_valid),
    .head_data  (head_data)
  );

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (halt_hit || timeout_hit) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_empty) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = DONE;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      cycle_cnt  <= '0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
      prev_pc    <= '0;
      prev_valid <= 1'b0;
      halt_cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == RUN) begin
        if (cycle_cnt != '1) begin
          cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
        prev_pc    <= f_pc;
        prev_valid <= 1'b1;
        halt_cnt   <= halt_cnt_next;
        if (timeout_hit) begin
          timeout <= 1'b1;
        end
        if (drop) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  assign out_valid = head_valid;
  assign {out_kind, out_pc, out_addr, out_data} = head_data;
  assign done = (state == DONE);

endmodule
